// File: rtl/rc5_pkg.sv
//------------------------------------------------------------------------------
// rc5_pkg
// Shared RC5 key-schedule types: magic constants, FSM states, word rotate.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rc5_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_L = 3'd1,
        INIT_S = 3'd2,
        MIX    = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic logic [63:0] pw(input int w);
        case (w)
            16:      return 64'h0000_0000_0000_B7E1;
            64:      return 64'hB7E1_5162_8AED_2A6B;
            default: return 64'h0000_0000_B7E1_5163;
        endcase
    endfunction

    function automatic logic [63:0] qw(input int w);
        case (w)
            16:      return 64'h0000_0000_0000_9E37;
            64:      return 64'h9E37_79B9_7F4A_7C15;
            default: return 64'h0000_0000_9E37_79B9;
        endcase
    endfunction

    // Rotate the low w bits of x left by amt (amt < w); bits above w are zero.
    function automatic logic [63:0] rotl(input logic [63:0] x, input int amt, input int w);
        logic [63:0] m;
        logic [63:0] xm;
        m  = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        xm = x & m;
        return ((xm << amt) | (xm >> (w - amt))) & m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rc5_mix_step.sv
//------------------------------------------------------------------------------
// rc5_mix_step
// One combinational A/B mixing iteration of the RC5 key schedule.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rc5_mix_step
    import rc5_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] i_s,
    input  logic [W-1:0] i_l,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_a,
    output logic [W-1:0] o_b
);

    localparam int c_rw = $clog2(W);

    logic [W-1:0] w_a_sum;
    logic [W-1:0] w_ab;
    logic [W-1:0] w_b_sum;

    always_comb begin
        w_a_sum = i_s + i_a + i_b;
        o_a     = W'(rotl(64'(w_a_sum), 3, W));
        w_ab    = o_a + i_b;
        w_b_sum = i_l + w_ab;
        // Data-dependent rotate uses only the low log2(W) bits of A'+B.
        o_b     = W'(rotl(64'(w_b_sum), int'(w_ab[c_rw-1:0]), W));
    end

endmodule

`default_nettype wire

// File: rtl/rc5_key_mixer.sv
//------------------------------------------------------------------------------
// rc5_key_mixer
// Loads C key words into L, fills S from Pw/Qw, runs the 3*max(T,C) mixing
// pass and holds S for random-access reads. KEY_ZEROIZE_EN adds a zeroize port.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rc5_key_mixer
    import rc5_pkg::*;
#(
    parameter int W = 32,
    parameter int T = 26,
    parameter int C = 4,
    parameter int U = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 l_valid,
    input  logic [W-1:0]         l_word,
    output logic                 l_ready,
    input  logic [$clog2(T)-1:0] s_rd_addr,
    output logic [W-1:0]         s_rd_data,
    output logic                 busy,
    output logic                 done
`ifdef KEY_ZEROIZE_EN
    ,
    input  logic                 zeroize
`endif
);

    localparam int c_aw_t  = $clog2(T);
    localparam int c_aw_c  = (C > 1) ? $clog2(C) : 1;
    localparam int c_iters = 3 * ((T > C) ? T : C);
    localparam int c_cw    = $clog2(c_iters);

    localparam logic [c_aw_t-1:0] c_t_last   = c_aw_t'(T - 1);
    localparam logic [c_aw_c-1:0] c_c_last   = c_aw_c'(C - 1);
    localparam logic [c_cw-1:0]   c_cnt_last = c_cw'(c_iters - 1);
    localparam logic [W-1:0]      c_pw       = W'(pw(W));
    localparam logic [W-1:0]      c_qw       = W'(qw(W));

    if (U * 8 != W || !(W == 16 || W == 32 || W == 64) || T < 2 || C < 1) begin : g_bad_param
        $error("rc5_key_mixer: inconsistent W/U/T/C parameters");
    end

    state_t            state_q, state_d;
    logic [c_aw_c-1:0] k_q, k_d;
    logic [c_aw_t-1:0] i_q, i_d;
    logic [c_aw_c-1:0] j_q, j_d;
    logic [c_cw-1:0]   cnt_q, cnt_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      s_q [T];
    logic [W-1:0]      s_d [T];
    logic [W-1:0]      l_q [C];
    logic [W-1:0]      l_d [C];

    logic [W-1:0]      w_a_new;
    logic [W-1:0]      w_b_new;
    logic [c_aw_t-1:0] w_prev;

    rc5_mix_step #(.W(W)) u_mix (
        .i_s (s_q[i_q]),
        .i_l (l_q[j_q]),
        .i_a (a_q),
        .i_b (b_q),
        .o_a (w_a_new),
        .o_b (w_b_new)
    );

    assign w_prev    = (i_q == '0) ? '0 : i_q - c_aw_t'(1);
    assign l_ready   = (state_q == LOAD_L);
    assign busy      = (state_q == LOAD_L) || (state_q == INIT_S) || (state_q == MIX);
    assign done      = (state_q == DONE);
    assign s_rd_data = (state_q == DONE && s_rd_addr <= c_t_last) ? s_q[s_rd_addr] : '0;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        i_d     = i_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        l_d     = l_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD_L;
                    l_d     = '{default: '0};
                    k_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                    cnt_d   = '0;
                    a_d     = '0;
                    b_d     = '0;
                end
            end
            LOAD_L: begin
                if (l_valid) begin
                    l_d[k_q] = l_word;
                    if (k_q == c_c_last) begin
                        k_d     = '0;
                        i_d     = '0;
                        state_d = INIT_S;
                    end else begin
                        k_d = k_q + c_aw_c'(1);
                    end
                end
            end
            INIT_S: begin
                s_d[i_q] = (i_q == '0) ? c_pw : s_q[w_prev] + c_qw;
                if (i_q == c_t_last) begin
                    i_d     = '0;
                    j_d     = '0;
                    a_d     = '0;
                    b_d     = '0;
                    cnt_d   = '0;
                    state_d = MIX;
                end else begin
                    i_d = i_q + c_aw_t'(1);
                end
            end
            MIX: begin
                s_d[i_q] = w_a_new;
                l_d[j_q] = w_b_new;
                a_d      = w_a_new;
                b_d      = w_b_new;
                i_d      = (i_q == c_t_last) ? '0 : i_q + c_aw_t'(1);
                j_d      = (j_q == c_c_last) ? '0 : j_q + c_aw_c'(1);
                if (cnt_q == c_cnt_last) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + c_cw'(1);
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef KEY_ZEROIZE_EN
        // Zeroize outranks start and any in-flight expansion.
        if (zeroize) begin
            state_d = IDLE;
            k_d     = '0;
            i_d     = '0;
            j_d     = '0;
            cnt_d   = '0;
            a_d     = '0;
            b_d     = '0;
            s_d     = '{default: '0};
            l_d     = '{default: '0};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '{default: '0};
            l_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            l_q     <= l_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rc5_key_mixer.sv
//------------------------------------------------------------------------------
// tb_rc5_key_mixer
// Directed bench for rc5_key_mixer at RC5-32/12/16, RC5-16/8/4 and c=30.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rc5_key_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        zeroize = 1'b0;

    logic        start = 1'b0, l_valid = 1'b0, l_ready, busy, done;
    logic [31:0] l_word = '0, s_rd_data;
    logic [4:0]  s_rd_addr = '0;

    logic        start16 = 1'b0, lv16 = 1'b0, ready16, busy16, done16;
    logic [15:0] lw16 = '0, data16;
    logic [4:0]  addr16 = '0;

    logic        start30 = 1'b0, lv30 = 1'b0, ready30, busy30, done30;
    logic [31:0] lw30 = '0, data30;
    logic [4:0]  addr30 = '0;

    int total = 0;
    int bad   = 0;

    logic [63:0] key_main [64];
    logic [63:0] key_alt  [64];
    logic [63:0] exp_s    [64];

    always #5 clk = ~clk;

    rc5_key_mixer #(.W(32), .T(26), .C(4), .U(4)) dut (
        .clk(clk), .rst(rst), .start(start), .l_valid(l_valid), .l_word(l_word),
        .l_ready(l_ready), .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data),
        .busy(busy), .done(done)
`ifdef KEY_ZEROIZE_EN
        , .zeroize(zeroize)
`endif
    );

    rc5_key_mixer #(.W(16), .T(18), .C(2), .U(2)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .l_valid(lv16), .l_word(lw16),
        .l_ready(ready16), .s_rd_addr(addr16), .s_rd_data(data16),
        .busy(busy16), .done(done16)
`ifdef KEY_ZEROIZE_EN
        , .zeroize(1'b0)
`endif
    );

    rc5_key_mixer #(.W(32), .T(26), .C(30), .U(4)) dut30 (
        .clk(clk), .rst(rst), .start(start30), .l_valid(lv30), .l_word(lw30),
        .l_ready(ready30), .s_rd_addr(addr30), .s_rd_data(data30),
        .busy(busy30), .done(done30)
`ifdef KEY_ZEROIZE_EN
        , .zeroize(1'b0)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] tb_rotl(input logic [63:0] x, input int r,
                                            input int w, input logic [63:0] m);
        if (r == 0) return x;
        return ((x << r) | (x >> (w - r))) & m;
    endfunction

    // Software RC5 key schedule; result lands in exp_s.
    function automatic void rc5_model(input int w, input int t, input int c,
                                      input logic [63:0] kin [64]);
        logic [63:0] m, p, q, a, b;
        logic [63:0] l [64];
        int i, j, nn;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        p = (w == 16) ? 64'hB7E1 : (w == 32) ? 64'hB7E1_5163 : 64'hB7E1_5162_8AED_2A6B;
        q = (w == 16) ? 64'h9E37 : (w == 32) ? 64'h9E37_79B9 : 64'h9E37_79B9_7F4A_7C15;
        for (int k = 0; k < c; k++) l[k] = kin[k] & m;
        exp_s[0] = p;
        for (int k = 1; k < t; k++) exp_s[k] = (exp_s[k-1] + q) & m;
        a = '0; b = '0; i = 0; j = 0;
        nn = 3 * ((t > c) ? t : c);
        for (int k = 0; k < nn; k++) begin
            a        = tb_rotl((exp_s[i] + a + b) & m, 3, w, m);
            exp_s[i] = a;
            b        = tb_rotl((l[j] + a + b) & m, int'(((a + b) & m) % 64'(w)), w, m);
            l[j]     = b;
            i        = (i + 1) % t;
            j        = (j + 1) % c;
        end
    endfunction

    task automatic check_main_table(input string tag);
        rc5_model(32, 26, 4, key_main);
        for (int k = 0; k < 26; k++) begin
            s_rd_addr = 5'(k);
            #1;
            check($sformatf("%s_s%0d", tag, k), 64'(s_rd_data), exp_s[k]);
        end
    endtask

    // Drives one expansion on the main instance. The word offered on the
    // start edge is bogus and must not be accepted.
    task automatic run_key(input string tag, input int stall_len, input int pulse_at,
                           input int exp_edges, input int abort_at);
        int n, acc, stall, rdy;
        n = 0; acc = 0; stall = stall_len; rdy = 0;
        @(negedge clk);
        start = 1'b1; l_valid = 1'b1; l_word = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_enter"}, 64'({busy, l_ready, done}), 64'b110);
        while (n < 600) begin
            l_valid = 1'b1;
            if (acc == 2 && stall > 0) begin
                l_valid = 1'b0;
                stall--;
            end
            l_word = (acc < 4) ? key_main[acc][31:0] : 32'hFFFF_FFFF;
            start  = (pulse_at > 0 && n + 1 == pulse_at);
            if (l_ready) rdy++;
            if (l_ready && l_valid) acc++;
            @(posedge clk);
            n++;
            @(negedge clk);
            start = 1'b0;
            if (abort_at > 0 && n == abort_at) return;
            if (done) break;
        end
        l_valid = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(exp_edges));
        check({tag, "_ready_cycles"}, 64'(rdy), 64'(4 + stall_len));
    endtask

    initial begin
        int n, acc;

        // Reset state
        #12;
        check("rst_outputs", 64'({l_ready, busy, done}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_outputs", 64'({l_ready, busy, done}), 64'd0);
        for (int k = 0; k < 26; k++) begin
            s_rd_addr = 5'(k);
            #1;
            check($sformatf("idle_rd%0d", k), 64'(s_rd_data), 64'd0);
        end

        // All-zero key
        for (int k = 0; k < 64; k++) key_main[k] = '0;
        run_key("zero", 0, 0, 108, 0);
        check_main_table("zero");
        repeat (5) @(negedge clk);
        check("done_held", 64'({done, busy}), 64'b10);

        // Same key with a 5-cycle l_valid gap; restart from DONE
        run_key("stall", 5, 0, 113, 0);
        check_main_table("stall");

        // start pulsed mid-MIX must be ignored
        run_key("pulse", 0, 50, 108, 0);
        check_main_table("pulse");

        // Byte-pattern key after a zero-key table
        key_main[0] = 64'h0302_0100; key_main[1] = 64'h0706_0504;
        key_main[2] = 64'h0B0A_0908; key_main[3] = 64'h0F0E_0D0C;
        run_key("bytes", 0, 0, 108, 0);
        check_main_table("bytes");

        // Asynchronous reset in the middle of MIX
        run_key("rstmix", 0, 0, 0, 60);
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async", 64'({l_ready, busy, done}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_key("after_rst", 0, 0, 108, 0);
        check_main_table("after_rst");

`ifdef KEY_ZEROIZE_EN
        @(negedge clk);
        zeroize = 1'b1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        zeroize = 1'b0;
        start   = 1'b0;
        check("zeroize_done", 64'({done, busy}), 64'd0);
        check("zeroize_rd", 64'(s_rd_data), 64'd0);
`endif

        // RC5-16/8/4
        key_alt[0] = 64'h1234; key_alt[1] = 64'hABCD;
        n = 0; acc = 0;
        @(negedge clk);
        start16 = 1'b1; lv16 = 1'b1; lw16 = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        while (n < 400) begin
            lw16 = (acc < 2) ? key_alt[acc][15:0] : 16'h0;
            if (ready16) acc++;
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done16) break;
        end
        lv16 = 1'b0;
        check("w16_latency", 64'(n), 64'(2 + 18 + 54));
        rc5_model(16, 18, 2, key_alt);
        for (int k = 0; k < 18; k++) begin
            addr16 = 5'(k);
            #1;
            check($sformatf("w16_s%0d", k), 64'(data16), exp_s[k]);
        end

        // c=30 > t=26
        for (int k = 0; k < 30; k++)
            key_alt[k] = 64'({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        n = 0; acc = 0;
        @(negedge clk);
        start30 = 1'b1; lv30 = 1'b1; lw30 = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        start30 = 1'b0;
        while (n < 600) begin
            lw30 = (acc < 30) ? key_alt[acc][31:0] : 32'h0;
            if (ready30) acc++;
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done30) break;
        end
        lv30 = 1'b0;
        check("c30_latency", 64'(n), 64'(30 + 26 + 90));
        rc5_model(32, 26, 30, key_alt);
        for (int k = 0; k < 26; k++) begin
            addr30 = 5'(k);
            #1;
            check($sformatf("c30_s%0d", k), 64'(data30), exp_s[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
